// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_async read-side blocks.
// Holds the state encoding, the common data width and a counter-width helper.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   // Width of a counter over 0..n-1, never below 1 bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Downstream valid/ready stream with burst framing.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
) ();
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_last;
   logic                  m_ready;

   modport master (output m_data, m_valid, m_last, input m_ready);
   modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry, in-order holding buffer for {last, data} words.
// Entry 0 is always the head; push and pop may occur in the same cycle.
module fifo_rd_skid_buf #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   occ
);

   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   occ_q, occ_d;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      occ_d = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) e0_d = push_data;
            else               e1_d = push_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; the new word lands behind whatever remains.
            if (occ_q == 2'd1) begin
               e0_d = push_data;
            end else begin
               e0_d = e1_q;
               e1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         occ_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         occ_q <= occ_d;
      end
   end

   assign head = e0_q;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side consumer for fifo_async: absorbs the FIFO's 1-cycle read latency,
// streams words downstream framed into bursts and counts completed bursts.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BURST_LEN  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   rd_clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   output logic                   fifo_rd_en,
   fifo_burst_reader_if.master    m,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   burst_cnt
);

   localparam int               BEAT_W   = idx_width(BURST_LEN);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

   state_e                 state_q, state_d;
   logic                   inflight_q, inflight_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;

   logic                   pop;
   logic [1:0]             occ;
   logic [DATA_WIDTH:0]    head;
   logic [2:0]             pend;

   fifo_rd_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
      .clk       (rd_clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({beat_q == BEAT_MAX, fifo_data}),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   always_comb begin
      pop = (occ != 2'd0) & m.m_ready;
      // Words held plus in flight after this cycle's pop; m_ready feeds the read strobe on purpose.
      pend = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_rd_en = (state_q == ACTIVE) & enable & ~fifo_empty & (pend < 3'd2);
      inflight_d = fifo_rd_en;

      beat_d = beat_q;
      if (inflight_q) beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);

      burst_cnt_d = burst_cnt_q + CNT_WIDTH'(pop & head[DATA_WIDTH]);

      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = ACTIVE;
         ACTIVE:  if (!enable) state_d = DRAIN;
         DRAIN: begin
            if (enable)                                   state_d = ACTIVE;
            else if ((occ == 2'd0) && !inflight_q)        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         inflight_q  <= 1'b0;
         beat_q      <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         beat_q      <= beat_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign m.m_valid = (occ != 2'd0);
   assign m.m_data  = head[DATA_WIDTH-1:0];
   assign m.m_last  = head[DATA_WIDTH];
   assign busy      = (state_q != IDLE);
   assign burst_cnt = burst_cnt_q;

endmodule
